// File: rtl/screen_sequencer.sv
// -----------------------------------------------------------------------------
// screen_sequencer
//
// Sequences the colour-picker UI. USB HID keycodes are turned into screen
// transitions (TITLE / PICK / CONFIRM / ERROR) and, while in PICK, into
// frame-paced cursor moves. A frame watchdog forces the ERROR screen when
// the VGA vertical-sync stops producing frame ticks.
//
// Ports
//   CLK        in   1   system clock
//   Reset_n    in   1   synchronous active-low reset
//   frame_clk  in   1   VGA vsync (synchronous to CLK); a rise is a frame tick
//   keycode    in   8   current HID keycode, 0x00 = no key
//   currScreen out  3   000 TITLE, 001 PICK, 010 CONFIRM, 111 ERROR
//   PickX      out 10   linear cursor x (fixed at CENTER_X)
//   PickY      out 10   linear cursor y
//   pickLRx    out 10   left/right cursor x
//   pickLRy    out 10   left/right cursor y (fixed at LR_Y)
//   close      out  1   close-armed indicator
// -----------------------------------------------------------------------------
module screen_sequencer #(
    parameter int CENTER_X      = 320,
    parameter int CENTER_Y      = 240,
    parameter int RADIUS        = 100,
    parameter int STEP          = 2,
    parameter int LR_Y          = 360,
    parameter int FRAME_TIMEOUT = 1000000
) (
    input  logic       CLK,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [2:0] currScreen,
    output logic [9:0] PickX,
    output logic [9:0] PickY,
    output logic [9:0] pickLRx,
    output logic [9:0] pickLRy,
    output logic       close
);

    typedef enum logic [2:0] {
        S_TITLE   = 3'b000,
        S_PICK    = 3'b001,
        S_CONFIRM = 3'b010,
        S_ERROR   = 3'b111
    } state_t;

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_C     = 8'h06;

    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] Y_LO   = 11'(CENTER_Y - RADIUS);
    localparam logic signed [10:0] Y_HI   = 11'(CENTER_Y + RADIUS);
    localparam logic signed [10:0] X_LO   = 11'(CENTER_X - RADIUS);
    localparam logic signed [10:0] X_HI   = 11'(CENTER_X + RADIUS);

    localparam logic [9:0]  CX_10      = 10'(CENTER_X);
    localparam logic [9:0]  CY_10      = 10'(CENTER_Y);
    localparam logic [9:0]  LRY_10     = 10'(LR_Y);
    localparam logic [20:0] WDOG_LIMIT = 21'(FRAME_TIMEOUT);

    // Move a cursor coordinate by a signed delta and clamp it into [lo, hi].
    function automatic logic [9:0] move_sat(
        input logic        [9:0]  cur,
        input logic signed [10:0] delta,
        input logic signed [10:0] lo,
        input logic signed [10:0] hi
    );
        logic signed [10:0] sum;
        sum = $signed({1'b0, cur}) + delta;
        if (sum < lo) begin
            move_sat = lo[9:0];
        end else if (sum > hi) begin
            move_sat = hi[9:0];
        end else begin
            move_sat = sum[9:0];
        end
    endfunction

    // Saturating increment so a long stall never wraps back below the limit.
    function automatic logic [20:0] wdog_inc(input logic [20:0] cnt);
        if (&cnt) begin
            wdog_inc = cnt;
        end else begin
            wdog_inc = cnt + 21'd1;
        end
    endfunction

    state_t      state_q, state_d;
    logic        close_q, close_d;
    logic [9:0]  picky_q, picky_d;
    logic [9:0]  lrx_q, lrx_d;
    logic [7:0]  key_q;
    logic        frame_q;
    logic [20:0] wdog_q, wdog_d;

    logic tick;
    logic press;
    logic expired;

    assign tick    = frame_clk & ~frame_q;
    assign press   = (keycode != key_q) && (keycode != 8'h00);
    // A tick in the same cycle clears the count, so it suppresses expiry.
    assign expired = (wdog_q >= WDOG_LIMIT) && !tick;
    assign wdog_d  = tick ? 21'd0 : wdog_inc(wdog_q);

    always_comb begin
        state_d = state_q;
        close_d = close_q;
        picky_d = picky_q;
        lrx_d   = lrx_q;

        if (expired && (state_q != S_ERROR)) begin
            // Watchdog expiry outranks every key event and cursor move.
            state_d = S_ERROR;
        end else begin
            case (state_q)
                S_TITLE: begin
                    if (press && (keycode == KEY_ENTER)) begin
                        state_d = S_PICK;
                        picky_d = CY_10;
                        lrx_d   = CX_10;
                    end
                end
                S_PICK: begin
                    if (press) begin
                        case (keycode)
                            KEY_C:     close_d = ~close_q;
                            KEY_ENTER: begin
                                if (close_q) begin
                                    state_d = S_TITLE;
                                    close_d = 1'b0;
                                end else begin
                                    state_d = S_CONFIRM;
                                end
                            end
                            KEY_ESC: begin
                                state_d = S_TITLE;
                                close_d = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                    // Moves follow the held key level, and only when we stay in PICK.
                    if (tick && (state_d == S_PICK)) begin
                        case (keycode)
                            KEY_W:   picky_d = move_sat(picky_q, -STEP_S, Y_LO, Y_HI);
                            KEY_S:   picky_d = move_sat(picky_q,  STEP_S, Y_LO, Y_HI);
                            KEY_A:   lrx_d   = move_sat(lrx_q,   -STEP_S, X_LO, X_HI);
                            KEY_D:   lrx_d   = move_sat(lrx_q,    STEP_S, X_LO, X_HI);
                            default: ;
                        endcase
                    end
                end
                S_CONFIRM: begin
                    if (press && (keycode == KEY_ENTER)) begin
                        state_d = S_PICK;
                    end else if (press && (keycode == KEY_ESC)) begin
                        state_d = S_TITLE;
                    end
                end
                S_ERROR: begin
                    if (press && (keycode == KEY_ESC)) begin
                        state_d = S_TITLE;
                        picky_d = CY_10;
                        lrx_d   = CX_10;
                        close_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_TITLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_q <= S_TITLE;
            close_q <= 1'b0;
            picky_q <= CY_10;
            lrx_q   <= CX_10;
            key_q   <= 8'h00;
            frame_q <= 1'b0;
            wdog_q  <= 21'd0;
        end else begin
            state_q <= state_d;
            close_q <= close_d;
            picky_q <= picky_d;
            lrx_q   <= lrx_d;
            key_q   <= keycode;
            frame_q <= frame_clk;
            wdog_q  <= wdog_d;
        end
    end

    assign currScreen = state_q;
    assign PickX      = CX_10;
    assign PickY      = picky_q;
    assign pickLRx    = lrx_q;
    assign pickLRy    = LRY_10;
    assign close      = close_q;

endmodule

// File: tb/tb_screen_sequencer.sv
module tb_screen_sequencer;

    logic       CLK = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [2:0] currScreen;
    logic [9:0] PickX, PickY, pickLRx, pickLRy;
    logic       close;

    int n_cmp = 0;
    int n_mis = 0;
    int phase = 0;
    bit fr_en = 1'b0;

    screen_sequencer #(
        .FRAME_TIMEOUT(50)
    ) dut (
        .CLK       (CLK),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .keycode   (keycode),
        .currScreen(currScreen),
        .PickX     (PickX),
        .PickY     (PickY),
        .pickLRx   (pickLRx),
        .pickLRy   (pickLRy),
        .close     (close)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    // frame_clk pulses high for one cycle out of every eight when enabled.
    task automatic step();
        @(posedge CLK);
        #1;
        phase++;
        frame_clk = fr_en && ((phase % 8) == 0);
    endtask

    // Wait for a frame pulse, let it be sampled, then one more cycle to settle.
    task automatic wait_tick();
        int n;
        n = 0;
        while ((frame_clk !== 1'b1) && (n < 20)) begin
            step();
            n++;
        end
        if (n >= 20) check_eq("tick_timeout", 32'(frame_clk), 32'd1);
        step();
        step();
    endtask

    task automatic key(input logic [7:0] k);
        keycode = k;
        step();
        step();
    endtask

    int exp_v;
    int n;

    initial begin
        // Reset
        Reset_n = 1'b0;
        repeat (3) step();
        Reset_n = 1'b1;
        step();
        check_eq("rst_screen", 32'(currScreen), 32'd0);
        check_eq("rst_pickx", 32'(PickX), 32'd320);
        check_eq("rst_picky", 32'(PickY), 32'd240);
        check_eq("rst_lrx", 32'(pickLRx), 32'd320);
        check_eq("rst_lry", 32'(pickLRy), 32'd360);
        check_eq("rst_close", 32'(close), 32'd0);
        fr_en = 1'b1;

        // Screen flow
        key(8'h28);
        check_eq("title_to_pick", 32'(currScreen), 32'd1);
        key(8'h00);
        key(8'h28);
        check_eq("pick_to_confirm", 32'(currScreen), 32'd2);
        key(8'h29);
        check_eq("confirm_esc", 32'(currScreen), 32'd0);
        key(8'h00);
        key(8'h28);
        check_eq("reenter_pick", 32'(currScreen), 32'd1);
        keycode = 8'h00;

        // Saturating W move
        wait_tick();
        keycode = 8'h1A;
        for (int i = 1; i <= 60; i++) begin
            wait_tick();
            exp_v = 240 - 2 * i;
            if (exp_v < 140) exp_v = 140;
            check_eq("w_picky", 32'(PickY), 32'(exp_v));
        end

        // Saturating D move
        keycode = 8'h07;
        for (int i = 1; i <= 120; i++) begin
            wait_tick();
            exp_v = 320 + 2 * i;
            if (exp_v > 420) exp_v = 420;
            if ((i % 10 == 0) || (i >= 48 && i <= 52)) check_eq("d_lrx", 32'(pickLRx), 32'(exp_v));
        end
        check_eq("d_picky_hold", 32'(PickY), 32'd140);
        check_eq("d_screen", 32'(currScreen), 32'd1);

        // Close path
        keycode = 8'h00;
        wait_tick();
        key(8'h06);
        check_eq("close_set", 32'(close), 32'd1);
        key(8'h28);
        check_eq("close_exit_screen", 32'(currScreen), 32'd0);
        check_eq("close_cleared", 32'(close), 32'd0);
        key(8'h00);
        key(8'h28);
        check_eq("reload_screen", 32'(currScreen), 32'd1);
        check_eq("reload_picky", 32'(PickY), 32'd240);
        check_eq("reload_lrx", 32'(pickLRx), 32'd320);

        // Collision: Enter press and tick in the same cycle
        keycode = 8'h00;
        wait_tick();
        keycode = 8'h1A;
        wait_tick();
        wait_tick();
        check_eq("coll_pre_picky", 32'(PickY), 32'd236);
        n = 0;
        while ((frame_clk !== 1'b1) && (n < 20)) begin
            step();
            n++;
        end
        if (n >= 20) check_eq("coll_tick_timeout", 32'(frame_clk), 32'd1);
        keycode = 8'h28;
        step();
        step();
        check_eq("coll_screen", 32'(currScreen), 32'd2);
        check_eq("coll_picky", 32'(PickY), 32'd236);
        key(8'h00);
        key(8'h28);
        check_eq("confirm_back_screen", 32'(currScreen), 32'd1);
        check_eq("confirm_back_picky", 32'(PickY), 32'd236);
        keycode = 8'h00;

        // Watchdog: last sampled tick, then frame_clk stops
        n = 0;
        while ((frame_clk !== 1'b1) && (n < 20)) begin
            step();
            n++;
        end
        if (n >= 20) check_eq("wd_tick_timeout", 32'(frame_clk), 32'd1);
        fr_en = 1'b0;
        step();
        repeat (50) step();
        check_eq("wd_before", 32'(currScreen), 32'd1);
        step();
        check_eq("wd_expired", 32'(currScreen), 32'd7);
        key(8'h28);
        check_eq("err_ignore_enter", 32'(currScreen), 32'd7);
        key(8'h1A);
        check_eq("err_ignore_w", 32'(currScreen), 32'd7);
        check_eq("err_picky_hold", 32'(PickY), 32'd236);
        key(8'h00);
        fr_en = 1'b1;
        repeat (10) step();
        check_eq("err_stays", 32'(currScreen), 32'd7);
        key(8'h29);
        check_eq("err_esc_screen", 32'(currScreen), 32'd0);
        check_eq("err_esc_picky", 32'(PickY), 32'd240);
        check_eq("err_esc_close", 32'(close), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
